// File: rtl/param_updown_counter_pkg.sv
// Shared encodings for the parametrised up/down counter.
package param_updown_counter_pkg;

    // Terminal-count behaviour selected by the mode input
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_RELOAD  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Run-control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : param_updown_counter_pkg

// File: rtl/param_updown_counter.sv
// Parametrised loadable up/down counter with terminal-count modes,
// a registered terminal-count pulse and a small run-control FSM.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] term_c;
    logic [WIDTH-1:0] step_c;
    logic             at_term_c;
    logic             step_hits_term_c;

    // Terminal value follows the current direction; plain +/-1 step modulo 2^WIDTH
    always_comb begin
        term_c           = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        step_c           = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        at_term_c        = (count_q == term_c);
        step_hits_term_c = (step_c == term_c);
    end

    // Next-state, next-count and terminal-pulse decode
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d  = RUN;
                    count_d  = data;
                    reload_d = data;
                end
            end

            RUN: begin
                if (load) begin
                    count_d  = data;
                    reload_d = data;
                end else if (en) begin
                    if (!at_term_c) begin
                        count_d = step_c;
                        tc_d    = step_hits_term_c;
                        if ((mode == MODE_ONESHOT) && step_hits_term_c) begin
                            state_d = DONE;
                        end
                    end else begin
                        case (mode)
                            MODE_WRAP: begin
                                // Modulo step from the terminal never lands on it again
                                count_d = step_c;
                            end
                            MODE_SAT: begin
                                count_d = count_q;
                            end
                            MODE_RELOAD: begin
                                count_d = reload_q;
                                tc_d    = (reload_q == term_c);
                            end
                            default: begin
                                // One-shot already sitting on terminal: stop the run
                                state_d = DONE;
                            end
                        endcase
                    end
                end
            end

            DONE: begin
                if (load) begin
                    state_d  = RUN;
                    count_d  = data;
                    reload_d = data;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    // State and output registers; synchronous reset discards any run in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= RST_VAL;
            reload_q <= RST_VAL;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule : param_updown_counter
